fir_tap_reader: RTL and testbench

Sample history buffer and sequential tap reader for the FIR datapath. Accepts one input sample per transaction over a valid/ready handshake and shifts it into a TAPS-deep delay line. It then reads the stored samples out one per cycle, newest first, over a second valid/ready handshake to the multiply-accumulate unit. It is the read side of the load-enabled sample registers, and the MAC sequences on its tap_idx and tap_last outputs.

---
 rtl/fir_tap_reader.sv | 91 +++++++++
 tb/tb_fir_tap_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_reader.sv
// Sample delay line with a sequential tap reader for the FIR MAC.
// Accepts one sample per handshake, shifts it in, then presents all stored taps newest-first.
module fir_tap_reader #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8,
    localparam int IDXW = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tap_valid,
    input  logic             tap_ready,
    output logic [WIDTH-1:0] tap_data,
    output logic [IDXW-1:0]  tap_idx,
    output logic             tap_last,
    output logic             primed
);

    localparam int CNTW = $clog2(TAPS + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TAPS - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(TAPS);

    typedef enum logic {IDLE, READ} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  x_q [TAPS];
    logic [WIDTH-1:0]  x_d [TAPS];

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    // Flush wins over a simultaneous sample; that sample is dropped.
                    for (int k = 0; k < TAPS; k++) x_d[k] = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    x_d[0] = in_data;
                    for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
                    idx_d   = '0;
                    state_d = READ;
                    if (cnt_q != FULL_CNT) cnt_d = cnt_q + CNTW'(1);
                end
            end
            READ: begin
                if (tap_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the sample registers are reset too, because tap_data must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign tap_valid = (state_q == READ);
    assign tap_data  = x_q[idx_q];
    assign tap_idx   = idx_q;
    assign tap_last  = (state_q == READ) && (idx_q == LAST_IDX);
    assign primed    = (cnt_q == FULL_CNT);

endmodule

// File: tb/tb_fir_tap_reader.sv
// Scoreboard bench for fir_tap_reader (TAPS=4, WIDTH=8): stimulus pushes expected taps,
// a negedge monitor pops and compares on every tap handshake.
module tb_fir_tap_reader;

    localparam int WIDTH = 8;
    localparam int TAPS  = 4;
    localparam int IDXW  = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [IDXW-1:0]  idx;
        logic             last;
    } tap_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             tap_valid;
    logic             tap_ready = 1'b1;
    logic [WIDTH-1:0] tap_data;
    logic [IDXW-1:0]  tap_idx;
    logic             tap_last;
    logic             primed;

    int checks = 0;
    int errors = 0;

    tap_t             exp_q[$];
    logic [WIDTH-1:0] hist [TAPS];
    int               cnt;

    fir_tap_reader #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_data(tap_data),
        .tap_idx(tap_idx), .tap_last(tap_last), .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake completes on the next rising edge, so compare just before it.
    always @(negedge clk) begin
        if (!rst && tap_valid && tap_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tap", {tap_data, tap_idx, tap_last}, 32'hdead);
            end else begin
                tap_t e;
                e = exp_q.pop_front();
                check("tap", {tap_data, 2'(tap_idx), tap_last}, {e.data, 2'(e.idx), e.last});
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) hist[k] = '0;
        cnt = 0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        check("in_ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
        if (cnt < TAPS) cnt++;
        for (int i = 0; i < TAPS; i++) begin
            tap_t t;
            t.data = hist[i];
            t.idx  = IDXW'(i);
            t.last = (i == TAPS - 1);
            exp_q.push_back(t);
        end
        check("first_tap_valid_idx0", {tap_valid, 2'(tap_idx), tap_data}, {1'b1, 2'd0, d});
        check("primed_on_accept", primed, (cnt == TAPS));
    endtask

    // Bounded wait for the sweep to finish; returns cycles spent after the accept edge.
    task automatic wait_idle(output int n);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("sweep_completes", in_ready, 1);
    endtask

    initial begin
        int n;
        model_reset();
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            check("idle_after_reset", {in_ready, tap_valid, tap_data, primed}, {1'b1, 1'b0, 8'h00, 1'b0});
            @(posedge clk); #1;
        end

        // Single sample, full-rate sweep
        send(8'h11);
        wait_idle(n);
        check("sweep_cycles_single", n, TAPS);

        // Priming and wrap of history
        send(8'h22); wait_idle(n);
        send(8'h33); wait_idle(n);
        check("not_primed_at_3", primed, 0);
        send(8'h44); wait_idle(n);
        check("sweep_cycles_4th", n, TAPS);
        check("primed_after_4", primed, 1);
        send(8'h55); wait_idle(n);
        check("primed_saturated", primed, 1);

        // Backpressure at idx 1 with a sample offered during READ
        send(8'h66);
        @(posedge clk); #1;
        tap_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {in_ready, tap_valid, 2'(tap_idx), tap_data}, {1'b0, 1'b1, 2'd1, 8'h55});
        end
        in_valid  = 1'b0;
        tap_ready = 1'b1;
        wait_idle(n);

        // clr with a simultaneous sample: flush wins, sample dropped
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        check("in_ready_during_clr", in_ready, 1);
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        model_reset();
        check("clr_drops_sample", {tap_valid, in_ready}, {1'b0, 1'b1});
        check("primed_cleared", primed, 0);
        send(8'h7F); wait_idle(n);

        // clr during READ is ignored
        send(8'h80);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        wait_idle(n);
        send(8'h81); wait_idle(n);

        // Async reset mid-sweep at idx 2
        send(8'h33);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("at_idx2_before_reset", {tap_valid, 2'(tap_idx)}, {1'b1, 2'd2});
        #2 rst = 1'b1;
        #1;
        check("async_reset_immediate", {in_ready, tap_valid, 2'(tap_idx), tap_data, tap_last, primed},
              {1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0});
        exp_q.delete();
        model_reset();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send(8'h01);
        wait_idle(n);
        check("sweep_cycles_after_reset", n, TAPS);

        @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
